// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, synchronous imem fetch, halt detection and perf counters
module fetch_unit #(
   parameter int PC_WIDTH = 10,
   parameter int INSTR_WIDTH = 9,
   parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = 9'h1FF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stall,
   input  logic                   jump,
   input  logic                   jump_taken,
   input  logic [PC_WIDTH-1:0]    jump_target,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic                   instr_valid,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic                   done,
   output logic [15:0]            cycle_count,
   output logic [15:0]            instr_count
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [PC_WIDTH-1:0] pc, next_pc;
   logic halt, clr, retire;
   assign halt = state == RUN && imem_rdata == HALT_INSTR;
   assign retire = state == RUN && !stall && !halt;
   always_comb begin
      state_nx = state;
      next_pc = pc;
      clr = 1'b0;
      case (state)
         IDLE: begin
            next_pc = '0;
            if (start) begin
               state_nx = RUN;
               clr = 1'b1;
            end
         end
         RUN:
            if (halt) state_nx = DONE;
            else if (!stall) next_pc = (jump && jump_taken) ? jump_target : pc + PC_WIDTH'(1);
         DONE:
            if (start) begin
               state_nx = RUN;
               next_pc = '0;
               clr = 1'b1;
            end
         default: state_nx = IDLE;
      endcase
   end
   // presenting next_pc keeps imem_rdata aligned with pc on the following cycle
   assign imem_addr = state == RUN ? next_pc : '0;
   assign instr_out = imem_rdata;
   assign instr_valid = state == RUN;
   assign pc_out = pc;
   assign done = state == DONE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc <= '0;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         state <= state_nx;
         pc <= next_pc;
         if (clr) begin
            cycle_count <= '0;
            instr_count <= '0;
         end else begin
            if (state == RUN && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
            if (retire && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven per-cycle vectors checked through a one-deep scoreboard
module tb_fetch_unit;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0, jump = 1'b0, jump_taken = 1'b0;
   logic [9:0] jump_target = '0, imem_addr, pc_out;
   logic [8:0] imem_rdata, instr_out;
   logic instr_valid, done;
   logic [15:0] cycle_count, instr_count;
   logic [8:0] mem [1024];
   int checks = 0, errors = 0, row = -1;

   typedef struct {
      logic [4:0] ctl;
      logic [9:0] tgt;
      logic [9:0] epc;
      logic [1:0] vd;
   } vec_t;
   typedef struct {
      logic [9:0] pc;
      logic v, d;
      logic [15:0] cyc, ins;
   } exp_t;
   vec_t tbl [32];
   exp_t sb [$];
   logic [9:0] m_pc = '0;
   logic m_v = 1'b0;
   logic [15:0] m_cyc = '0, m_ins = '0;

   fetch_unit dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .jump(jump),
      .jump_taken(jump_taken), .jump_target(jump_target), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
      .pc_out(pc_out), .done(done), .cycle_count(cycle_count), .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   always_ff @(posedge clk) imem_rdata <= mem[imem_addr];

   function automatic vec_t mk(logic [4:0] c, logic [9:0] t, logic [9:0] p, logic [1:0] vd);
      mk.ctl = c; mk.tgt = t; mk.epc = p; mk.vd = vd;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s row %0d actual %0h required %0h", name, row, act, req);
      end
   endtask

   // ctl = {reset, start, stall, jump, jump_taken}
   task automatic apply(vec_t v);
      exp_t e;
      {reset, start, stall, jump, jump_taken} = v.ctl;
      jump_target = v.tgt;
      e.pc = v.epc; e.v = v.vd[1]; e.d = v.vd[0]; e.cyc = m_cyc; e.ins = m_ins;
      if (v.ctl[4] || (!m_v && v.ctl[3])) begin
         e.cyc = '0; e.ins = '0;
      end else if (m_v) begin
         if (m_cyc != 16'hFFFF) e.cyc = m_cyc + 16'd1;
         if (!v.ctl[2] && mem[m_pc] != 9'h1FF && m_ins != 16'hFFFF) e.ins = m_ins + 16'd1;
      end
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("pc_out", 32'(pc_out), 32'(e.pc));
      chk("instr_valid", 32'(instr_valid), 32'(e.v));
      chk("done", 32'(done), 32'(e.d));
      chk("cycle_count", 32'(cycle_count), 32'(e.cyc));
      chk("instr_count", 32'(instr_count), 32'(e.ins));
      if (e.v) chk("instr_out", 32'(instr_out), 32'(mem[e.pc]));
      else chk("imem_addr", 32'(imem_addr), 32'd0);
      m_pc = e.pc; m_v = e.v; m_cyc = e.cyc; m_ins = e.ins;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = {1'b0, i[7:0]};
      mem[5] = 9'h1FF;
      mem[10'h061] = 9'h1FF;
      tbl[0]  = mk(5'b01000, 10'h000, 10'h000, 2'b10);
      tbl[1]  = mk(5'b00000, 10'h000, 10'h001, 2'b10);
      tbl[2]  = mk(5'b00000, 10'h000, 10'h002, 2'b10);
      tbl[3]  = mk(5'b00000, 10'h000, 10'h003, 2'b10);
      tbl[4]  = mk(5'b00000, 10'h000, 10'h004, 2'b10);
      tbl[5]  = mk(5'b00000, 10'h000, 10'h005, 2'b10);
      tbl[6]  = mk(5'b00000, 10'h000, 10'h005, 2'b01);
      tbl[7]  = mk(5'b00011, 10'h040, 10'h005, 2'b01);
      tbl[8]  = mk(5'b01000, 10'h000, 10'h000, 2'b10);
      tbl[9]  = mk(5'b01000, 10'h000, 10'h001, 2'b10);
      tbl[10] = mk(5'b01000, 10'h000, 10'h002, 2'b10);
      tbl[11] = mk(5'b00000, 10'h000, 10'h003, 2'b10);
      tbl[12] = mk(5'b00011, 10'h040, 10'h040, 2'b10);
      tbl[13] = mk(5'b00011, 10'h003, 10'h003, 2'b10);
      tbl[14] = mk(5'b00010, 10'h040, 10'h004, 2'b10);
      tbl[15] = mk(5'b00011, 10'h3FF, 10'h3FF, 2'b10);
      tbl[16] = mk(5'b00000, 10'h000, 10'h000, 2'b10);
      tbl[17] = mk(5'b00000, 10'h000, 10'h001, 2'b10);
      tbl[18] = mk(5'b00000, 10'h000, 10'h002, 2'b10);
      tbl[19] = mk(5'b00111, 10'h060, 10'h002, 2'b10);
      tbl[20] = mk(5'b00111, 10'h060, 10'h002, 2'b10);
      tbl[21] = mk(5'b00111, 10'h060, 10'h002, 2'b10);
      tbl[22] = mk(5'b00011, 10'h060, 10'h060, 2'b10);
      tbl[23] = mk(5'b00000, 10'h000, 10'h061, 2'b10);
      tbl[24] = mk(5'b00111, 10'h010, 10'h061, 2'b01);
      tbl[25] = mk(5'b01011, 10'h010, 10'h000, 2'b10);
      tbl[26] = mk(5'b00011, 10'h006, 10'h006, 2'b10);
      tbl[27] = mk(5'b00000, 10'h000, 10'h007, 2'b10);
      tbl[28] = mk(5'b10011, 10'h020, 10'h000, 2'b00);
      tbl[29] = mk(5'b00011, 10'h020, 10'h000, 2'b00);
      tbl[30] = mk(5'b01000, 10'h000, 10'h000, 2'b10);
      tbl[31] = mk(5'b00000, 10'h000, 10'h001, 2'b10);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pc_out", 32'(pc_out), 32'd0);
      chk("reset_imem_addr", 32'(imem_addr), 32'd0);
      chk("reset_instr_valid", 32'(instr_valid), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_cycle_count", 32'(cycle_count), 32'd0);
      chk("reset_instr_count", 32'(instr_count), 32'd0);
      for (int i = 0; i < 32; i++) begin
         row = i;
         apply(tbl[i]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter, drives a synchronous-read instruction memory, and presents one 9-bit instruction per cycle, with a valid flag, to the decoder. Consumes the decoder's jump indication plus a branch-taken condition to redirect the PC. Provides start/done program sequencing, halt detection and performance counters.

## Interface

- PC_WIDTH, 10, program counter and instruction memory address width
- INSTR_WIDTH, 9, instruction width
- HALT_INSTR, 9'h1FF, encoding that terminates the program
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  begin program at PC 0; sampled in IDLE and DONE only
- stall  input  1  freeze PC and hold current instruction
- jump  input  1  from control unit: current instruction is a jump or branch
- jump_taken  input  1  branch condition; 1 for unconditional jumps
- jump_target  input  PC_WIDTH  absolute redirect address
- imem_addr  output  PC_WIDTH  combinational read address to instruction memory
- imem_rdata  input  INSTR_WIDTH  memory data; equals mem[address presented the previous cycle]
- instr_out  output  INSTR_WIDTH  instruction to control unit; passes imem_rdata through
- instr_valid  output  1  instr_out is a live instruction
- pc_out  output  PC_WIDTH  address of instr_out
- done  output  1  program halted
- cycle_count  output  16  cycles spent in RUN, saturating
- instr_count  output  16  instructions retired, saturating

## Operation

- States: IDLE, RUN, DONE.
- IDLE: pc=0, imem_addr=0. If start=1, go to RUN, clear both counters, and keep pc=0.
- RUN: instr_valid=1. next_pc is selected in this priority order:
  - halt: instr_out==HALT_INSTR. Go to DONE and hold pc.
  - stall=1: next_pc=pc.
  - jump & jump_taken: next_pc=jump_target.
  - otherwise: next_pc=pc+1, wrapping modulo 2^PC_WIDTH (PC 2^PC_WIDTH-1 goes to 0).
- imem_addr=next_pc, and pc is registered from next_pc. This keeps instr_out aligned with pc_out with no bubble, and a stall re-reads the same word.
- Retire: an instruction retires when instr_valid=1, stall=0 and it is not the halt instruction. Each retire increments instr_count.
- cycle_count increments on every RUN cycle, including stall and halt cycles.
- Both counters saturate at 16'hFFFF.
- DONE: done=1, instr_valid=0, pc and counters hold. imem_addr=0. start=1 returns to RUN, with pc=0, counters cleared and done cleared on the next cycle.
- start is ignored in RUN.
- jump with jump_taken=0 behaves as a sequential fetch.
- jump and stall inputs are ignored when instr_valid=0.

## Timing

- Reset values: pc_out=0, imem_addr=0, instr_valid=0, done=0, cycle_count=0, instr_count=0, state IDLE.
- Reset asserted mid-RUN: returns to IDLE on the next edge. Any in-progress jump is dropped.
- start sampled high at edge E: instr_valid=1 and pc_out=0 in the cycle after E. instr_out=mem[0] in that cycle, because the address was 0 during IDLE.
- Sequential fetch: one instruction per cycle, zero bubble.
- Taken jump decoded in cycle N: pc_out=jump_target and instr_out=mem[jump_target] in cycle N+1. No squash is required.
- Stall in cycle N: pc_out and instr_out are identical in cycle N+1. A jump presented during a stall takes effect in the first non-stalled cycle.
- Halt seen in cycle N:
  - done=1 and instr_valid=0 from cycle N+1.
  - The halt has priority over a simultaneous jump and over a simultaneous stall.
  - The halt is not counted as retired.
- done stays asserted until reset or start.

## Test plan

- Linear program: mem[0..4] = distinct non-jump words, mem[5]=1FF. Pulse start. Required: pc_out 0,1,2,3,4,5 on consecutive cycles; then done=1 and instr_valid=0; instr_count=5; cycle_count=6.
- Taken jump: at pc=3 drive jump=1, jump_taken=1, jump_target=10'h040. Required: next cycle pc_out=0x040 and instr_out=mem[0x40]. Repeat with jump_taken=0. Required: pc_out=4.
- Stall: hold stall=1 for 3 cycles at pc=2, with jump=1 also asserted. Required: pc_out=2 and instr_out constant for 3 cycles; instr_count unchanged; then pc_out=jump_target.
- Wrap-around: jump to 0x3FF where mem[0x3FF] is a non-jump word. Required: next pc_out=0x000.
- Halt priority and restart: halt word with jump=1 and stall=1 asserted. Required: done=1 the next cycle and pc_out held. Then pulse start. Required: pc_out=0, done=0, counters cleared.
- Reset mid-run: assert reset at pc=7. Required: next cycle pc_out=0, instr_valid=0, done=0, counters=0, and start is required to resume.
